// File: rtl/pwm_duty_decoder.sv
// Multi-channel PWM receiver: per-channel synchroniser, rising-edge detector and
// period/high-time counters, reporting a registered duty/period with a one-cycle valid.
module pwm_duty_decoder #(
  parameter int CHANNELS = 8,
  parameter int DUTY_W   = 8,
  parameter int PER_W    = 10,
  parameter int TIMEOUT  = 600
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHANNELS-1:0]        pwm_in,
  output logic [CHANNELS*DUTY_W-1:0] duty,
  output logic [CHANNELS*PER_W-1:0]  period,
  output logic [CHANNELS-1:0]        valid,
  output logic [CHANNELS-1:0]        stuck
);

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  localparam logic [PER_W-1:0]  PER_MAX   = {PER_W{1'b1}};
  localparam logic [PER_W-1:0]  TIMEOUT_V = PER_W'(TIMEOUT);
  localparam logic [PER_W-1:0]  PER_ONE   = PER_W'(1);
  localparam int unsigned       DUTY_MAX  = (2 ** DUTY_W) - 1;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic             s1, s2, s3;
    logic             rise, timeout;
    state_t           state_q, state_d;
    logic [PER_W-1:0] pcnt_q, pcnt_d;
    logic [PER_W-1:0] hcnt_q, hcnt_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [PER_W-1:0] per_q, per_d;
    logic             valid_q, valid_d;
    logic             stuck_q, stuck_d;

    assign rise    = s2 & ~s3;
    assign timeout = ~rise && (pcnt_q == TIMEOUT_V);

    always_ff @(posedge clk) begin
      if (rst) begin
        s1      <= 1'b0;
        s2      <= 1'b0;
        s3      <= 1'b0;
        state_q <= IDLE;
        pcnt_q  <= '0;
        hcnt_q  <= '0;
        duty_q  <= '0;
        per_q   <= '0;
        valid_q <= 1'b0;
        stuck_q <= 1'b0;
      end else begin
        s1      <= pwm_in[g];
        s2      <= s1;
        s3      <= s2;
        state_q <= state_d;
        pcnt_q  <= pcnt_d;
        hcnt_q  <= hcnt_d;
        duty_q  <= duty_d;
        per_q   <= per_d;
        valid_q <= valid_d;
        stuck_q <= stuck_d;
      end
    end

    // A rise outranks a coincident timeout; the first rise after IDLE only arms.
    always_comb begin
      state_d = state_q;
      pcnt_d  = (pcnt_q == PER_MAX) ? pcnt_q : pcnt_q + PER_ONE;
      hcnt_d  = hcnt_q;
      duty_d  = duty_q;
      per_d   = per_q;
      valid_d = 1'b0;
      stuck_d = stuck_q;
      if (s2 && hcnt_q != PER_MAX) begin
        hcnt_d = hcnt_q + PER_ONE;
      end
      if (rise) begin
        pcnt_d = PER_ONE;
        hcnt_d = PER_ONE;
        if (state_q == MEAS) begin
          duty_d  = (32'(hcnt_q) > DUTY_MAX) ? {DUTY_W{1'b1}} : DUTY_W'(hcnt_q);
          per_d   = pcnt_q;
          valid_d = 1'b1;
          stuck_d = 1'b0;
        end else begin
          state_d = MEAS;
        end
      end else if (timeout) begin
        duty_d  = s2 ? {DUTY_W{1'b1}} : '0;
        per_d   = '0;
        valid_d = 1'b1;
        stuck_d = 1'b1;
        state_d = IDLE;
        pcnt_d  = '0;
        hcnt_d  = '0;
      end
    end

    assign duty[g*DUTY_W +: DUTY_W] = duty_q;
    assign period[g*PER_W +: PER_W] = per_q;
    assign valid[g]                 = valid_q;
    assign stuck[g]                 = stuck_q;
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Bench for pwm_duty_decoder: per-channel waveform generators, a timestamp-based
// reference model with an expected-report queue, directed scenarios and random rounds.
module tb_pwm_duty_decoder;
  localparam int CH = 8;
  localparam int DW = 8;
  localparam int PW = 10;
  localparam int TO = 600;

  logic             clk = 1'b0;
  logic             rst;
  logic [CH-1:0]    pwm_in;
  logic [CH*DW-1:0] duty;
  logic [CH*PW-1:0] period;
  logic [CH-1:0]    valid;
  logic [CH-1:0]    stuck;

  always #5 clk = ~clk;

  pwm_duty_decoder #(.CHANNELS(CH), .DUTY_W(DW), .PER_W(PW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .duty(duty), .period(period), .valid(valid), .stuck(stuck)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waveform generators: high while (cyc + off) mod p < h, or a constant level.
  int gp[CH], gh[CH], goff[CH];
  bit gconst[CH], glvl[CH];
  int cyc = 0;
  bit rst_drv = 1'b0;

  function automatic logic gen_bit(input int i);
    if (gconst[i]) return glvl[i];
    return ((cyc + goff[i]) % gp[i]) < gh[i];
  endfunction

  // Reference model: the line as seen after two sync stages; pcnt expressed as
  // edge_n - t0, where t0 is the last rise edge or one past the last reset/timeout edge.
  bit m_s1[CH], m_s2[CH], m_s3[CH], m_armed[CH];
  int m_t0[CH], m_high[CH];
  int edge_n = 0;
  logic [DW-1:0] e_duty[CH];
  logic [PW-1:0] e_per[CH];
  bit e_stuck[CH], e_valid[CH];
  logic [22:0] exp_q[$];

  int rep_cnt[CH], stk_cnt[CH];
  logic [DW-1:0] last_duty[CH];
  logic [PW-1:0] last_per[CH];
  bit last_stuck[CH];

  task automatic report(input int i, input int d, input int p, input bit s);
    e_duty[i]  = DW'(d);
    e_per[i]   = PW'(p);
    e_stuck[i] = s;
    e_valid[i] = 1'b1;
    exp_q.push_back({4'(i), s, DW'(d), PW'(p)});
  endtask

  task automatic model_step();
    edge_n++;
    for (int i = 0; i < CH; i++) begin
      e_valid[i] = 1'b0;
      if (rst_drv) begin
        m_s1[i] = 0; m_s2[i] = 0; m_s3[i] = 0;
        m_armed[i] = 0; m_high[i] = 0; m_t0[i] = edge_n + 1;
        e_duty[i] = '0; e_per[i] = '0; e_stuck[i] = 1'b0;
      end else begin
        if (m_s2[i] && !m_s3[i]) begin
          if (m_armed[i]) report(i, (m_high[i] > 255) ? 255 : m_high[i], edge_n - m_t0[i], 1'b0);
          m_armed[i] = 1; m_t0[i] = edge_n; m_high[i] = 1;
        end else if (edge_n - m_t0[i] == TO) begin
          report(i, m_s2[i] ? 255 : 0, 0, 1'b1);
          m_armed[i] = 0; m_t0[i] = edge_n + 1; m_high[i] = 0;
        end else if (m_s2[i]) begin
          m_high[i]++;
        end
        m_s3[i] = m_s2[i]; m_s2[i] = m_s1[i]; m_s1[i] = pwm_in[i];
      end
    end
  endtask

  task automatic compare();
    logic [CH*DW-1:0] ed;
    logic [CH*PW-1:0] ep;
    logic [CH-1:0]    ev, es;
    for (int i = 0; i < CH; i++) begin
      ed[i*DW +: DW] = e_duty[i];
      ep[i*PW +: PW] = e_per[i];
      ev[i] = e_valid[i];
      es[i] = e_stuck[i];
    end
    check_eq("valid", 128'(valid), 128'(ev));
    check_eq("stuck", 128'(stuck), 128'(es));
    check_eq("duty", 128'(duty), 128'(ed));
    check_eq("period", 128'(period), 128'(ep));
    for (int i = 0; i < CH; i++) begin
      if (valid[i]) begin
        if (exp_q.size() > 0)
          check_eq("report", 128'({4'(i), stuck[i], duty[i*DW +: DW], period[i*PW +: PW]}),
                   128'(exp_q.pop_front()));
        else
          check_eq("spurious_valid", 128'(valid[i]), 128'(0));
        rep_cnt[i]++;
        if (stuck[i]) stk_cnt[i]++;
        last_duty[i]  = duty[i*DW +: DW];
        last_per[i]   = period[i*PW +: PW];
        last_stuck[i] = stuck[i];
      end
    end
    check_eq("missed_report", 128'(exp_q.size()), 128'(0));
    exp_q.delete();
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < CH; i++) pwm_in[i] = gen_bit(i);
    rst = rst_drv;
    cyc++;
    @(posedge clk);
    model_step();
    #1 compare();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset(input int n);
    rst_drv = 1'b1;
    run(n);
    rst_drv = 1'b0;
  endtask

  task automatic all_quiet();
    for (int i = 0; i < CH; i++) begin
      gconst[i] = 1'b1; glvl[i] = 1'b0; gp[i] = 1; gh[i] = 0; goff[i] = 0;
    end
    cyc = 0;
  endtask

  task automatic set_pwm(input int i, input int p, input int h, input int off);
    gconst[i] = 1'b0; gp[i] = p; gh[i] = h; goff[i] = off;
  endtask

  task automatic clear_mon();
    for (int i = 0; i < CH; i++) begin
      rep_cnt[i] = 0; stk_cnt[i] = 0;
    end
  endtask

  task automatic check_last(input string tag, input int i, input int d, input int p, input bit s);
    check_eq({tag, "_duty"}, 128'(last_duty[i]), 128'(d));
    check_eq({tag, "_period"}, 128'(last_per[i]), 128'(p));
    check_eq({tag, "_stuck"}, 128'(last_stuck[i]), 128'(s));
  endtask

  initial begin
    rst = 1'b1;
    pwm_in = '0;
    all_quiet();
    clear_mon();
    do_reset(3);
    check_eq("reset_outputs", 128'({duty, period, valid, stuck}), 128'(0));

    // 64/256 on channel 0: first rise arms, then one report per frame.
    all_quiet(); set_pwm(0, 256, 64, 0);
    do_reset(2); clear_mon(); run(1200);
    check_eq("p1_count", 128'(rep_cnt[0]), 128'(4));
    check_last("p1", 0, 64, 256, 1'b0);

    // Eight channels, high time 32*i; channel 0 never high and times out.
    all_quiet();
    for (int i = 0; i < CH; i++) set_pwm(i, 256, 32 * i, 0);
    do_reset(2); clear_mon(); run(1300);
    check_eq("p2_ch0_count", 128'(rep_cnt[0]), 128'(2));
    check_last("p2_ch0", 0, 0, 0, 1'b1);
    for (int i = 1; i < CH; i++) check_last("p2_chn", i, 32 * i, 256, 1'b0);

    // Channel 2 stuck high after one rise, then a 100/200 waveform.
    all_quiet();
    do_reset(2); clear_mon(); run(5);
    glvl[2] = 1'b1; run(1250);
    check_eq("p3_stuck_count", 128'(rep_cnt[2]), 128'(2));
    check_last("p3_stuck", 2, 255, 0, 1'b1);
    set_pwm(2, 200, 100, 150); cyc = 0; clear_mon(); run(500);
    check_eq("p3_rearm_count", 128'(rep_cnt[2]), 128'(2));
    check_last("p3_rearm", 2, 100, 200, 1'b0);

    // High time beyond the duty range saturates.
    all_quiet(); set_pwm(3, 400, 300, 0);
    do_reset(2); clear_mon(); run(1300);
    check_eq("p4_count", 128'(rep_cnt[3]), 128'(3));
    check_last("p4", 3, 255, 400, 1'b0);

    // One-cycle reset in the middle of a measurement.
    all_quiet(); set_pwm(0, 256, 64, 0);
    do_reset(2); run(700);
    do_reset(1);
    check_eq("p5_after_rst", 128'({duty, period, valid, stuck}), 128'(0));
    clear_mon(); run(300);
    check_eq("p5_no_report", 128'(rep_cnt[0]), 128'(0));
    run(200);
    check_eq("p5_count", 128'(rep_cnt[0]), 128'(1));
    check_last("p5", 0, 64, 256, 1'b0);

    // Period exactly TIMEOUT: the rise wins over the timeout.
    all_quiet(); set_pwm(4, 600, 10, 590);
    do_reset(2); clear_mon(); run(1900);
    check_eq("p6_count", 128'(rep_cnt[4]), 128'(3));
    check_eq("p6_no_timeout", 128'(stk_cnt[4]), 128'(0));
    check_last("p6", 4, 10, 600, 1'b0);

    // Random rounds, checked cycle by cycle against the model.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          gconst[i] = 1'b1; glvl[i] = 1'($urandom_range(0, 1));
        end else begin
          set_pwm(i, 0, 0, 0);
          gp[i] = $urandom_range(2, 700);
          gh[i] = $urandom_range(0, gp[i]);
          goff[i] = $urandom_range(0, gp[i] - 1);
        end
      end
      if (r == 0 || $urandom_range(0, 1) == 1) do_reset(int'($urandom_range(1, 3)));
      run(int'($urandom_range(600, 1500)));
      if ($urandom_range(0, 2) == 0) do_reset(1);
      run(int'($urandom_range(300, 900)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
